m_apb_mic: RTL
==============

Name: m_apb_mic

Overview:
APB completer to MIC requester bridge. An APB requester (e.g. a debug/DMA-lite controller on the peripheral bus) issues 32-bit single-word accesses into MIC address space. Each APB transfer becomes exactly one MIC request packet; the APB transfer is held with PREADY low until the MIC response packet has been fully consumed. clk and the MIC clock are the same domain.

Parameters:
APB_ADDR_BITS, 16, width of PADDR; low bits of the MIC address come from PADDR.
MIC_BASE_ADDR, 32'h8000_0000, supplies MIC address bits [31:APB_ADDR_BITS].
ROUTE, 8'h00, value placed in the request route field [55:48].

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
PADDR  in  APB_ADDR_BITS  APB byte address; bits [1:0] ignored
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write
PWDATA  in  32  write data
PRDATA  out  32  read data, valid while PREADY=1
PREADY  out  1  transfer complete
PSLVERR  out  1  error flag (see Optional Feature)
O_TVALID  out  1  MIC request valid
O_TREADY  in  1  MIC request accepted
O_TDATA  out  64  MIC request beat
O_TLAST  out  1  last beat of request
I_TVALID  in  1  MIC response valid
I_TREADY  out  1  ready for response beat
I_TDATA  in  64  MIC response beat
I_TLAST  in  1  last beat of response

Behaviour:
- Reset values: state=IDLE; O_TVALID=0, O_TLAST=0, I_TREADY=0, PREADY=0, PSLVERR=0, PRDATA=0.
- Capture: while in IDLE, PSEL=1 and PENABLE=0 (setup phase) latches PADDR, PWRITE and PWDATA. Next state is WHDR if the write flag is set, RHDR otherwise. PSEL=1 with PENABLE=1 in IDLE (protocol error) is ignored.
- MIC address: maddr = {MIC_BASE_ADDR[31:APB_ADDR_BITS], PADDR[APB_ADDR_BITS-1:2], 2'b00}; hi = maddr[2].
- Request header: [63:56] byte enables (hi ? 8'hF0 : 8'h0F), [55:48] ROUTE, [47:40] rlen=0, [33:32] type (00 RD, 01 WR), [31:3] maddr[31:3], [2:0]=0, all other bits 0.
- O_TDATA is a registered output. It is stable while O_TVALID=1 and O_TREADY=0.
- States:
  - WHDR: O_TVALID=1 with the header, O_TLAST=0. On O_TREADY go to WDATA.
  - WDATA: O_TVALID=1, O_TLAST=1, data beat = hi ? {PWDATA,32'h0} : {32'h0,PWDATA}. On O_TREADY go to RESP.
  - RHDR: O_TVALID=1, O_TLAST=1, header only. On O_TREADY go to RESP.
  - RESP: I_TREADY=1. Beat 0 is the response header: bit 33 = response, bit 32 = type. For a read, beat 1 supplies PRDATA = hi ? I_TDATA[63:32] : I_TDATA[31:0]. Any further beats are discarded. On an accepted beat with I_TLAST=1 go to DONE.
  - DONE: PREADY=1 for exactly one cycle with PRDATA valid, then return to IDLE.
  - Write ack is a single header beat with I_TLAST=1.
- PREADY=0 in every state except DONE, including the setup cycle.
- Minimum latency, setup cycle to PREADY: write 4 cycles, read 4 cycles when the response data beat immediately follows the header.
- Read response with only a header beat (TLAST on header): PRDATA=0, still completes.
- I_TREADY=0 outside RESP. Unsolicited responses stall the response channel; they are not dropped.
- O_TVALID never asserts in IDLE, RESP or DONE. At most one MIC transaction is outstanding.
- Reset mid-operation: reset returns to IDLE immediately and clears all outputs. A partially sent request packet is not completed; the system resets the interconnect together with this block.

Optional Feature:
APB_MIC_RESPCHECK_EN
- Defined: the response header is checked. If bit 33=0, or bit 32 ≠ captured type, an error flag is set. The remaining beats are still drained until I_TLAST. In DONE, PSLVERR=1 and PRDATA=0. The flag clears on leaving DONE.
- Undefined: no header check; PSLVERR is tied to 0.

Test Plan:
- Write: PADDR=16'h0104, PWDATA=32'hCAFEF00D, defaults -> O_TDATA header 64'hF000_0001_8000_0100 (O_TLAST=0), then 64'hCAFEF00D_0000_0000 (O_TLAST=1); ack 64'h0000_0003_8000_0100 with TLAST -> PREADY=1 for one cycle, 4 cycles after setup.
- Read: PADDR=16'h0010 -> single beat 64'h0F00_0000_8000_0010 with O_TLAST=1; response header then 64'h11223344_55667788 -> PRDATA=32'h55667788, PREADY one cycle.
- Backpressure: O_TREADY low for 5 cycles during WHDR -> O_TVALID=1 and O_TDATA unchanged throughout; PREADY stays 0; completion 5 cycles later than the unstalled case.
- Burst response: read response with header plus 3 data beats (TLAST on last) -> all beats accepted, PRDATA taken from the first data beat, single PREADY pulse.
- Reset asserted in RESP -> next cycle IDLE, I_TREADY=0, PREADY=0, O_TVALID=0; a new APB read then completes normally.
- APB_MIC_RESPCHECK_EN: read response header with bit 33=0 -> PSLVERR=1 and PRDATA=0 in the PREADY cycle; the following transfer has PSLVERR=0.

Source files
------------

// File: rtl/m_apb_mic.sv
// rtl/m_apb_mic.sv - APB completer to MIC requester bridge, one MIC packet per APB transfer.
// Define APB_MIC_RESPCHECK_EN to check response headers and report failures on PSLVERR.
module m_apb_mic #(
    parameter int          APB_ADDR_BITS = 16,
    parameter logic [31:0] MIC_BASE_ADDR = 32'h8000_0000,
    parameter logic [7:0]  ROUTE         = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [APB_ADDR_BITS-1:0] PADDR,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [31:0]              PWDATA,
    output logic [31:0]              PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    output logic                     O_TVALID,
    input  logic                     O_TREADY,
    output logic [63:0]              O_TDATA,
    output logic                     O_TLAST,
    input  logic                     I_TVALID,
    output logic                     I_TREADY,
    input  logic [63:0]              I_TDATA,
    input  logic                     I_TLAST
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WHDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_RHDR  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Word address only; the byte offset bits have no meaning on a 32-bit single-word bus.
    logic unused_paddr;
    assign unused_paddr = ^PADDR[1:0];

    function automatic logic [63:0] mk_header(input logic [APB_ADDR_BITS-1:2] a, input logic wr);
        mk_header = {a[2] ? 8'hF0 : 8'h0F, ROUTE, 8'h00, 6'b0, 1'b0, wr,
                     MIC_BASE_ADDR[31:APB_ADDR_BITS], a[APB_ADDR_BITS-1:3], 3'b000};
    endfunction

    logic [2:0]  state_q, state_d;
    logic        hi_q, hi_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] odata_q, odata_d;
    logic [31:0] prdata_q, prdata_d;
    // Response beat index, saturating: 0 header, 1 first data beat, 2 anything after.
    logic [1:0]  beat_q, beat_d;
`ifdef APB_MIC_RESPCHECK_EN
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        odata_d  = odata_q;
        prdata_d = prdata_q;
        beat_d   = beat_q;
`ifdef APB_MIC_RESPCHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    hi_d     = PADDR[2];
                    wr_d     = PWRITE;
                    wdata_d  = PWDATA;
                    odata_d  = mk_header(PADDR[APB_ADDR_BITS-1:2], PWRITE);
                    prdata_d = 32'h0;
                    beat_d   = 2'd0;
`ifdef APB_MIC_RESPCHECK_EN
                    err_d    = 1'b0;
`endif
                    state_d  = PWRITE ? S_WHDR : S_RHDR;
                end
            end
            S_WHDR: begin
                if (O_TREADY) begin
                    odata_d = hi_q ? {wdata_q, 32'h0} : {32'h0, wdata_q};
                    state_d = S_WDATA;
                end
            end
            S_WDATA, S_RHDR: begin
                if (O_TREADY) state_d = S_RESP;
            end
            S_RESP: begin
                if (I_TVALID) begin
`ifdef APB_MIC_RESPCHECK_EN
                    if (beat_q == 2'd0 && (!I_TDATA[33] || I_TDATA[32] != wr_q)) err_d = 1'b1;
`endif
                    if (beat_q == 2'd1 && !wr_q)
                        prdata_d = hi_q ? I_TDATA[63:32] : I_TDATA[31:0];
                    if (beat_q != 2'd2) beat_d = beat_q + 2'd1;
                    if (I_TLAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef APB_MIC_RESPCHECK_EN
                err_d   = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            hi_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= 32'h0;
            odata_q  <= 64'h0;
            prdata_q <= 32'h0;
            beat_q   <= 2'd0;
`ifdef APB_MIC_RESPCHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            odata_q  <= odata_d;
            prdata_q <= prdata_d;
            beat_q   <= beat_d;
`ifdef APB_MIC_RESPCHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign O_TVALID = (state_q == S_WHDR) || (state_q == S_WDATA) || (state_q == S_RHDR);
    assign O_TLAST  = (state_q == S_WDATA) || (state_q == S_RHDR);
    assign O_TDATA  = odata_q;
    assign I_TREADY = (state_q == S_RESP);
    assign PREADY   = (state_q == S_DONE);
`ifdef APB_MIC_RESPCHECK_EN
    assign PSLVERR  = (state_q == S_DONE) && err_q;
    assign PRDATA   = ((state_q == S_DONE) && err_q) ? 32'h0 : prdata_q;
`else
    assign PSLVERR  = 1'b0;
    assign PRDATA   = prdata_q;
`endif

endmodule
